// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, addresses instruction memory and fills
// the IF/ID register. Handles stall, branch/jump redirect with flush, and HALT.
module fetch_unit #(
  parameter int                 PC_W       = 8,
  parameter int                 INSTR_W    = 16,
  parameter logic [PC_W-1:0]    RESET_PC   = 8'h00,
  parameter logic [INSTR_W-1:0] HALT_INSTR = 16'hFFFF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [PC_W-1:0]    branch_target,
  input  logic               jump,
  input  logic [PC_W-1:0]    jump_target,
  output logic [PC_W-1:0]    pc_out,
  input  logic [INSTR_W-1:0] instr_in,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic [PC_W-1:0]    if_id_pc1,
  output logic               if_id_valid,
  output logic               halted
);

  // state   | meaning
  // RUN     | fetching one instruction per cycle
  // HALT    | HALT opcode seen; PC frozen, bubbles into IF/ID until redirect
  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_HALT = 1'b1;

  logic [0:0]         state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [PC_W-1:0]    pc1_q, pc1_d;
  logic               valid_q, valid_d;
  logic [PC_W-1:0]    pc_inc;

  assign pc_inc = pc_q + PC_W'(1);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    pc1_d   = pc1_q;
    valid_d = valid_q;
    // The EX-stage branch is older than the ID-stage jump, so it wins.
    if (branch_taken || jump) begin
      pc_d    = branch_taken ? branch_target : jump_target;
      instr_d = '0;
      pc1_d   = '0;
      valid_d = 1'b0;
      state_d = ST_RUN;
    end else if (stall) begin
      state_d = state_q;
    end else if (state_q == ST_RUN) begin
      instr_d = instr_in;
      pc1_d   = pc_inc;
      valid_d = 1'b1;
      if (instr_in == HALT_INSTR) begin
        state_d = ST_HALT;
      end else begin
        pc_d = pc_inc;
      end
    end else begin
      instr_d = '0;
      pc1_d   = '0;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      pc1_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc1_q   <= pc1_d;
      valid_q <= valid_d;
    end
  end

  assign pc_out      = pc_q;
  assign if_id_instr = instr_q;
  assign if_id_pc1   = pc1_q;
  assign if_id_valid = valid_q;
  assign halted      = (state_q == ST_HALT);

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios then random traffic, each cycle
// compared against a cycle-level reference model of the fetch behaviour.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst, stall, branch_taken, jump;
  logic [7:0]  branch_target, jump_target, pc_out, if_id_pc1;
  logic [15:0] instr_in, if_id_instr;
  logic        if_id_valid, halted;

  logic [15:0] mem [256];
  int checks = 0;
  int errors = 0;

  // reference model state
  int          m_pc, m_pc1;
  logic [15:0] m_instr;
  logic        m_valid, m_halt;

  always #5 clk = ~clk;

  assign instr_in = mem[pc_out];

  fetch_unit dut (
    .clk(clk), .rst(rst), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target),
    .pc_out(pc_out), .instr_in(instr_in),
    .if_id_instr(if_id_instr), .if_id_pc1(if_id_pc1),
    .if_id_valid(if_id_valid), .halted(halted)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    logic [15:0] fetched;
    fetched = mem[m_pc];
    if (rst) begin
      m_pc = 0; m_pc1 = 0; m_instr = 0; m_valid = 0; m_halt = 0;
    end else if (branch_taken || jump) begin
      m_pc = branch_taken ? int'(branch_target) : int'(jump_target);
      m_pc1 = 0; m_instr = 0; m_valid = 0; m_halt = 0;
    end else if (stall) begin
      // everything holds
    end else if (!m_halt) begin
      m_instr = fetched;
      m_pc1   = (m_pc + 1) % 256;
      m_valid = 1;
      if (fetched == 16'hFFFF) m_halt = 1;
      else m_pc = (m_pc + 1) % 256;
    end else begin
      m_pc1 = 0; m_instr = 0; m_valid = 0;
    end
  endtask

  task automatic step(input logic r, input logic s, input logic b, input logic [7:0] bt,
                      input logic j, input logic [7:0] jt);
    rst = r; stall = s; branch_taken = b; branch_target = bt; jump = j; jump_target = jt;
    model_edge();
    @(posedge clk);
    #1;
    chk("pc_out", 32'(pc_out), 32'(m_pc));
    chk("if_id_instr", 32'(if_id_instr), 32'(m_instr));
    chk("if_id_pc1", 32'(if_id_pc1), 32'(m_pc1));
    chk("if_id_valid", 32'(if_id_valid), 32'(m_valid));
    chk("halted", 32'(halted), 32'(m_halt));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 8'h00, 0, 8'h00);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i] = 16'($urandom);
      if (mem[i] == 16'hFFFF) mem[i] = 16'h0000;
    end
    mem[0] = 16'h1111; mem[1] = 16'h2222; mem[2] = 16'h3333; mem[3] = 16'h4444;
    mem[4] = 16'h5555; mem[5] = 16'hFFFF; mem[8'h40] = 16'h4040; mem[8'hFF] = 16'hABCD;
    m_pc = 0; m_pc1 = 0; m_instr = 0; m_valid = 0; m_halt = 0;
    rst = 1; stall = 0; branch_taken = 0; jump = 0; branch_target = 0; jump_target = 0;

    // reset, then sequential fetch
    step(1, 0, 0, 8'h00, 0, 8'h00);
    step(1, 0, 0, 8'h00, 0, 8'h00);
    chk("reset_valid", 32'(if_id_valid), 32'd0);
    chk("reset_pc", 32'(pc_out), 32'h00);
    run(1);
    chk("t1_instr0", 32'(if_id_instr), 32'h1111);
    chk("t1_pc1_0", 32'(if_id_pc1), 32'h01);
    run(1);
    chk("t1_instr1", 32'(if_id_instr), 32'h2222);
    chk("t1_pc_2", 32'(pc_out), 32'h02);

    // stall for three cycles at pc=2
    for (int i = 0; i < 3; i++) step(0, 1, 0, 8'h00, 0, 8'h00);
    chk("t2_stall_pc", 32'(pc_out), 32'h02);
    chk("t2_stall_instr", 32'(if_id_instr), 32'h2222);
    run(1);
    chk("t2_release_instr", 32'(if_id_instr), 32'h3333);
    chk("t2_release_pc1", 32'(if_id_pc1), 32'h03);

    // branch beats jump beats stall
    step(0, 1, 1, 8'h40, 1, 8'h80);
    chk("t3_pc", 32'(pc_out), 32'h40);
    chk("t3_flush", 32'(if_id_valid), 32'd0);
    run(1);
    chk("t3_fetch", 32'(if_id_instr), 32'h4040);

    // halt and resume
    step(0, 0, 0, 8'h00, 1, 8'h04);
    run(2);
    chk("t4_halt_instr", 32'(if_id_instr), 32'hFFFF);
    chk("t4_halt_valid", 32'(if_id_valid), 32'd1);
    chk("t4_halted", 32'(halted), 32'd1);
    chk("t4_halt_pc", 32'(pc_out), 32'h05);
    run(2);
    chk("t4_bubble", 32'(if_id_valid), 32'd0);
    step(0, 1, 0, 8'h00, 0, 8'h00);
    step(0, 0, 0, 8'h00, 1, 8'h10);
    chk("t4_resume_halted", 32'(halted), 32'd0);
    chk("t4_resume_pc", 32'(pc_out), 32'h10);
    run(1);
    chk("t4_resume_pc2", 32'(pc_out), 32'h11);

    // PC wrap
    step(0, 0, 0, 8'h00, 1, 8'hFF);
    chk("t5_pc_ff", 32'(pc_out), 32'hFF);
    run(1);
    chk("t5_wrap_pc", 32'(pc_out), 32'h00);
    chk("t5_wrap_pc1", 32'(if_id_pc1), 32'h00);
    chk("t5_wrap_instr", 32'(if_id_instr), 32'hABCD);

    // reset mid-stream
    step(0, 0, 0, 8'h00, 1, 8'h20);
    run(3);
    chk("t6_pre_pc", 32'(pc_out), 32'h23);
    step(1, 0, 1, 8'h55, 0, 8'h00);
    chk("t6_pc", 32'(pc_out), 32'h00);
    chk("t6_valid", 32'(if_id_valid), 32'd0);
    chk("t6_halted", 32'(halted), 32'd0);

    // random traffic with sprinkled HALT opcodes
    for (int i = 0; i < 256; i++)
      if ($urandom_range(0, 19) == 0) mem[i] = 16'hFFFF;
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 49) == 0, $urandom_range(0, 4) == 0,
           $urandom_range(0, 9) == 0, 8'($urandom),
           $urandom_range(0, 9) == 0, 8'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
